// File: rtl/pp_gen_seq.sv
// Sequential 8x8 partial-product generator.
// A single 4x4 unsigned multiplier is time-shared over four cycles to produce
// the four 8-bit partial products of an 8x8 multiply. The downstream adder tree
// rebuilds the full product as {pp_hh, pp_ll} + (pp_hl << 4) + (pp_lh << 4).
module pp_gen_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] pp_ll,
  output logic [7:0] pp_lh,
  output logic [7:0] pp_hl,
  output logic [7:0] pp_hh
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e     state_q;
  logic [1:0] step_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [7:0] pp_ll_q;
  logic [7:0] pp_lh_q;
  logic [7:0] pp_hl_q;
  logic [7:0] pp_hh_q;
  logic       in_ready_q;
  logic       out_valid_q;

  logic [3:0] mul_a;
  logic [3:0] mul_b;
  logic [7:0] mul_p;

  // Operand select for the shared multiplier: step[1] picks the half of a,
  // step[0] picks the half of b, giving ll, lh, hl, hh for steps 0..3.
  always_comb begin
    mul_a = step_q[1] ? a_q[7:4] : a_q[3:0];
    mul_b = step_q[0] ? b_q[7:4] : b_q[3:0];
    mul_p = {4'b0000, mul_a} * {4'b0000, mul_b};
  end

  // Control FSM with operand capture, product registers and registered handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      step_q      <= 2'd0;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      pp_ll_q     <= 8'h00;
      pp_lh_q     <= 8'h00;
      pp_hl_q     <= 8'h00;
      pp_hh_q     <= 8'h00;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            step_q     <= 2'd0;
            state_q    <= StMul;
            in_ready_q <= 1'b0;
          end
        end
        StMul: begin
          unique case (step_q)
            2'd0: pp_ll_q <= mul_p;
            2'd1: pp_lh_q <= mul_p;
            2'd2: pp_hl_q <= mul_p;
            2'd3: pp_hh_q <= mul_p;
          endcase
          step_q <= step_q + 2'd1;
          if (step_q == 2'd3) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          // A new operand pair is not taken here even if presented; it waits for IDLE.
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign pp_ll     = pp_ll_q;
  assign pp_lh     = pp_lh_q;
  assign pp_hl     = pp_hl_q;
  assign pp_hh     = pp_hh_q;

endmodule

// File: tb/tb_pp_gen_seq.sv
// Bench for pp_gen_seq: table vectors, hand-written corner sequences and a
// randomized run against a transaction-level timing/arithmetic model.
module tb_pp_gen_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pp_ll;
  logic [7:0] pp_lh;
  logic [7:0] pp_hl;
  logic [7:0] pp_hh;
  logic [31:0] dut_pp;

  int checks = 0;
  int errors = 0;

  pp_gen_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pp_ll     (pp_ll),
    .pp_lh     (pp_lh),
    .pp_hl     (pp_hl),
    .pp_hh     (pp_hh)
  );

  always #5 clk = ~clk;

  assign dut_pp = {pp_hh, pp_hl, pp_lh, pp_ll};

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] pp;   // {hh, hl, lh, ll}
    logic [15:0] prod;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Partial products straight from the half-operand definitions.
  function automatic logic [31:0] pp_model(input logic [7:0] a, input logic [7:0] b);
    int al, ah, bl, bh;
    al = int'(a) % 16;
    ah = int'(a) / 16;
    bl = int'(b) % 16;
    bh = int'(b) / 16;
    return {8'(ah * bh), 8'(ah * bl), 8'(al * bh), 8'(al * bl)};
  endfunction

  function automatic logic [15:0] recon(input logic [31:0] pp);
    logic [15:0] r;
    r = {pp[31:24], pp[7:0]};
    r = r + {4'b0000, pp[23:16], 4'b0000};
    r = r + {4'b0000, pp[15:8], 4'b0000};
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic start(input logic [7:0] a, input logic [7:0] b, input string tag);
    chk({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid; optionally scrambles inputs while busy.
  task automatic wait_done(input string tag, input bit scramble);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      if (scramble) begin
        chk({tag, " in_ready while busy"}, 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_a = 8'($urandom);
        in_b = 8'($urandom);
      end
      tick();
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'd4);
  endtask

  task automatic check_pp(input logic [7:0] a, input logic [7:0] b, input string tag);
    chk({tag, " pp"}, dut_pp, pp_model(a, b));
    chk({tag, " reconstruct"}, 32'(recon(dut_pp)), 32'(16'(a) * 16'(b)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          busy;
    bit          exp_valid;
    int          acc;
    logic [7:0]  ea, eb;
    logic [31:0] last;

    vecs[0] = '{a: 8'h12, b: 8'h34, pp: 32'h03040608, prod: 16'h03A8};
    vecs[1] = '{a: 8'hFF, b: 8'hFF, pp: 32'hE1E1E1E1, prod: 16'hFE01};
    vecs[2] = '{a: 8'h00, b: 8'h00, pp: 32'h00000000, prod: 16'h0000};
    vecs[3] = '{a: 8'hA5, b: 8'h3C, pp: 32'h1E780F3C, prod: 16'h26AC};
    vecs[4] = '{a: 8'h0F, b: 8'hF0, pp: 32'h0000E100, prod: 16'h0E10};

    in_valid  = 1'b0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    out_ready = 1'b1;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset pp", dut_pp, 32'h0);

    // Table vectors
    for (int i = 0; i < 5; i++) begin
      start(vecs[i].a, vecs[i].b, "vec");
      wait_done("vec", 1'b0);
      chk("vec pp", dut_pp, vecs[i].pp);
      chk("vec reconstruct", 32'(recon(dut_pp)), 32'(vecs[i].prod));
      tick();
      chk("vec idle in_ready", 32'(in_ready), 32'd1);
      chk("vec idle out_valid", 32'(out_valid), 32'd0);
      chk("vec pp retained", dut_pp, vecs[i].pp);
    end

    // Backpressure for 10 cycles, then simultaneous out_ready and in_valid
    out_ready = 1'b0;
    start(8'h12, 8'h34, "bp");
    wait_done("bp", 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      tick();
      chk("bp out_valid held", 32'(out_valid), 32'd1);
      chk("bp in_ready low", 32'(in_ready), 32'd0);
      chk("bp pp stable", dut_pp, 32'h03040608);
    end
    in_a = 8'hA5;
    in_b = 8'h3C;
    out_ready = 1'b1;
    tick();
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    chk("bp release out_valid", 32'(out_valid), 32'd0);
    chk("bp release pp kept", dut_pp, 32'h03040608);
    tick();
    in_valid = 1'b0;
    chk("bp late accept in_ready", 32'(in_ready), 32'd0);
    wait_done("bp2", 1'b0);
    check_pp(8'hA5, 8'h3C, "bp2");
    tick();

    // Operands changing every cycle during MUL are ignored
    start(8'h5A, 8'hC3, "scr");
    wait_done("scr", 1'b1);
    in_valid = 1'b0;
    check_pp(8'h5A, 8'hC3, "scr");
    tick();
    chk("scr idle in_ready", 32'(in_ready), 32'd1);

    // Reset at MUL step 2
    start(8'h12, 8'h34, "rstmul");
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmul out_valid", 32'(out_valid), 32'd0);
    chk("rstmul in_ready", 32'(in_ready), 32'd1);
    chk("rstmul pp", dut_pp, 32'h0);
    start(8'h00, 8'h00, "zero");
    wait_done("zero", 1'b0);
    check_pp(8'h00, 8'h00, "zero");
    tick();

    // Reset in DONE wins over handshakes
    out_ready = 1'b0;
    start(8'hFF, 8'hFF, "rstdone");
    wait_done("rstdone", 1'b0);
    rst = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rstdone out_valid", 32'(out_valid), 32'd0);
    chk("rstdone in_ready", 32'(in_ready), 32'd1);
    chk("rstdone pp", dut_pp, 32'h0);
    tick();
    chk("rstdone no pulse", 32'(out_valid), 32'd0);

    // Randomized run against a transaction-level model
    do_reset();
    busy = 1'b0;
    acc  = 0;
    ea   = 8'h00;
    eb   = 8'h00;
    last = 32'h0;
    for (int c = 0; c < 800; c++) begin
      exp_valid = busy && (c >= acc + 4);
      chk("rnd in_ready", 32'(in_ready), 32'(!busy));
      chk("rnd out_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid) begin
        check_pp(ea, eb, "rnd");
      end else if (!busy) begin
        chk("rnd idle pp", dut_pp, last);
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      if (!busy && in_valid) begin
        busy = 1'b1;
        acc  = c + 1;
        ea   = in_a;
        eb   = in_b;
      end else if (exp_valid && out_ready) begin
        busy = 1'b0;
        last = pp_model(ea, eb);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pp_gen_seq.md
PP_GEN_SEQ -- requirements
Module: pp_gen_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 8-bit operands, 4-bit halves and 8-bit partial products.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand pair on in_a/in_b is valid.
REQ-005 in_ready  output  1  block can accept an operand pair this cycle.
REQ-006 in_a  input  8  unsigned multiplicand.
REQ-007 in_b  input  8  unsigned multiplier.
REQ-008 out_valid  output  1  pp_hh/pp_hl/pp_lh/pp_ll hold a complete, consistent set.
REQ-009 out_ready  input  1  downstream final adder tree accepts the set.
REQ-010 pp_ll  output  8  in_a[3:0] * in_b[3:0].
REQ-011 pp_lh  output  8  in_a[3:0] * in_b[7:4].
REQ-012 pp_hl  output  8  in_a[7:4] * in_b[3:0].
REQ-013 pp_hh  output  8  in_a[7:4] * in_b[7:4].

Function
REQ-014 The block SHALL contain exactly one 4x4 unsigned multiplier (8-bit result), time-shared across the four partial products.
REQ-015 The FSM SHALL have three states: IDLE, MUL, DONE. A 2-bit step counter SHALL be used in MUL.
REQ-016 IDLE: in_ready=1, out_valid=0. When in_valid=1, in_a/in_b SHALL be captured into internal operand registers, the counter SHALL be cleared to 0, and the FSM SHALL go to MUL.
REQ-017 MUL: in_ready=0, out_valid=0. Each cycle SHALL compute one product from the captured operands and register it: step 0 to pp_ll, step 1 to pp_lh, step 2 to pp_hl, step 3 to pp_hh. The counter SHALL increment after each step. After step 3 the FSM SHALL go to DONE.
REQ-018 DONE: in_ready=0, out_valid=1. The pp outputs SHALL be held stable. When out_ready=1 the FSM SHALL go to IDLE.
REQ-019 Latency: out_valid SHALL rise exactly 4 cycles after the accepting edge (in_valid and in_ready both high) when out_ready is held high. Minimum initiation interval SHALL be 6 cycles (IDLE, 4xMUL, DONE).
REQ-020 Input handshake: in_valid, in_a and in_b SHALL be ignored outside IDLE. Operand changes after capture SHALL NOT affect the results.
REQ-021 Backpressure: while out_ready=0 in DONE, the FSM SHALL remain in DONE indefinitely with outputs unchanged.
REQ-022 Simultaneous out_ready and a new in_valid in DONE: the DONE handshake SHALL complete and the new operand pair SHALL NOT be accepted that cycle. It SHALL be accepted in the following IDLE cycle if still valid.
REQ-023 After the DONE handshake, the pp outputs SHALL retain their values until overwritten by the next MUL sequence.
REQ-024 Arithmetic: each product SHALL be an exact unsigned 4x4 product (max 0xE1), with no truncation. The downstream tree SHALL reconstruct in_a*in_b as {pp_hh,pp_ll} + (pp_hl<<4) + (pp_lh<<4).

Reset
REQ-025 With rst=1 at a rising edge: FSM goes to IDLE, counter=0, operand registers=0, pp_ll/pp_lh/pp_hl/pp_hh=0x00, out_valid=0.
REQ-026 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-027 Reset during MUL or DONE SHALL abort the operation with no out_valid pulse for it. rst SHALL take priority over every handshake in the same cycle.

Verification
REQ-028 in_a=0x12, in_b=0x34, out_ready=1 -> 4 cycles later out_valid=1 with pp_ll=0x08, pp_lh=0x06, pp_hl=0x04, pp_hh=0x03; reconstructed product is 0x03A8.
REQ-029 in_a=0xFF, in_b=0xFF -> all four pp=0xE1; reconstructed product is 0xFE01.
REQ-030 out_ready=0 for 10 cycles in DONE -> out_valid stays 1, pp outputs stable, in_ready=0; raise out_ready -> next cycle in_ready=1.
REQ-031 in_valid held high with in_a/in_b changing every cycle during MUL -> results match the operands captured at acceptance; no second capture until IDLE.
REQ-032 rst asserted at MUL step 2 -> next cycle all pp=0x00, out_valid=0, in_ready=1; a following 0x00*0x00 operation yields all pp=0x00 with out_valid after 4 cycles.
REQ-033 Random back-to-back operations with random out_ready -> every output set equals the 4x4 products of its captured operands, and the reconstructed result equals in_a*in_b.
